multi_clock_gate_ctrl: RTL
==========================

Name: multi_clock_gate_ctrl

Overview:
- Parametrised multi-channel clock-gating controller for the low-power system.
- Each channel has its own request/acknowledge handshake and a wake-up delay before the acknowledge.
- A channel gates its clock off automatically after a programmable number of idle cycles.
- Each channel drives its block's clock through a glitch-free integrated clock gate: a latch transparent while CLK is low, followed by an AND. The block sits between the system controller and the power-managed sub-blocks (UART, ALU, register file).

Parameters:
- NUM_CH, 4, number of independently gated clock channels (1..16)
- CNT_W, 8, width of the idle-timeout counter and of IDLE_LIMIT
- WAKE_CYC, 2, gated-clock cycles delivered before CH_ACK asserts (1..15)

Ports:
- CLK  input  1  source clock for all channels
- RST  input  1  asynchronous, active-high reset
- GLOBAL_EN  input  1  master enable; low forces every channel to OFF
- CH_REQ  input  NUM_CH  per-channel clock request (level)
- CH_BUSY  input  NUM_CH  per-channel busy flag from the clocked block; holds the clock on
- CH_FORCE_ON  input  NUM_CH  test/debug override; keeps the channel clock running
- IDLE_LIMIT  input  CNT_W  idle cycles tolerated before gating off; shared by all channels
- GATED_CLK  output  NUM_CH  gated clock per channel
- CH_ACK  output  NUM_CH  channel clock is stable and running
- GATE_EN  output  NUM_CH  registered-state enable presented to each latch (observability)
- CH_STATE  output  2*NUM_CH  per-channel FSM state; channel i occupies bits [2i+1:2i]

Behaviour:
- Each channel has an independent FSM, encoded OFF=00, WAKE=01, ON=10, IDLE=11. All FSM state and counters update on the CLK rising edge.
- Reset (RST=1, asynchronous):
  - FSM=OFF, counters=0, latch output=0.
  - GATED_CLK=0, CH_ACK=0, GATE_EN=0, CH_STATE=0.
  - Asserting RST mid-operation clears the latches immediately; a truncated high pulse on GATED_CLK is accepted.
- Define act = CH_REQ | CH_BUSY | CH_FORCE_ON.
- Priority 1: GLOBAL_EN=0 sends every channel to OFF at the next edge, from any state, overriding busy and force.
- OFF:
  - Exit to WAKE when GLOBAL_EN=1 and act=1.
  - Entering WAKE loads the wake counter with 0.
- WAKE:
  - The wake counter increments every cycle.
  - Transition to ON when the count reaches WAKE_CYC-1; WAKE therefore lasts exactly WAKE_CYC cycles.
  - A request dropping during WAKE does not abort it: the FSM reaches ON, then follows the ON rules.
- ON:
  - If act=0 and IDLE_LIMIT≠0: go to IDLE and clear the idle counter.
  - If act=0 and IDLE_LIMIT=0: go directly to OFF.
- IDLE:
  - If act=1: return to ON; the idle counter is not used.
  - Otherwise the idle counter increments; when it equals IDLE_LIMIT-1, go to OFF.
  - IDLE_LIMIT is sampled every cycle. If it changes to a value at or below the current count, the channel goes to OFF at the next edge.
  - The idle counter saturates and never wraps.
- GATE_EN = (state≠OFF), decoded from registered state.
- Latch and gate:
  - The latch is transparent while CLK=0 and captures GATE_EN.
  - GATED_CLK = CLK & latch.
  - The first gated rising edge is the CLK edge after the one that entered WAKE. The last gated edge is the one that entered OFF.
  - No glitch on GATED_CLK while GATE_EN toggles during CLK high.
- CH_ACK = (state==ON), registered decode. CH_ACK is 0 in WAKE and IDLE.
- Request-to-ACK latency from the edge that samples CH_REQ high: WAKE_CYC+1 edges.
- Channels are fully independent. Simultaneous requests on all channels wake together and add no arbitration delay.

Test Plan:
- Reset, then hold RST low with no requests for 20 cycles -> GATED_CLK stays 0, CH_ACK=0, CH_STATE=0. Assert RST while channel 0 is in ON -> GATED_CLK[0] drops immediately and CH_STATE returns to 0.
- WAKE_CYC=2, IDLE_LIMIT=3. Raise CH_REQ[1] at edge 0 -> GATED_CLK[1] pulses from edge 1. CH_ACK[1] goes high after edge 3.
- Same settings. Drop CH_REQ[1] at edge 10 -> IDLE from edge 10. OFF entered at edge 13; edge 13 is the last gated pulse. CH_ACK[1] low from edge 10.
- Hold CH_BUSY[2]=1 with CH_REQ[2]=0 -> channel stays ON and the clock never gates. Re-raise CH_REQ[2] during IDLE count 1 -> returns to ON, no OFF visit.
- IDLE_LIMIT=0 -> ON goes to OFF in one edge once act drops. With channels 0–3 all ON, pulse GLOBAL_EN low for one cycle -> all four go OFF, including a channel with CH_FORCE_ON set. They rewake only if act=1.
- Random CH_REQ/CH_BUSY over 10k cycles -> GATED_CLK high time never shorter than a CLK high phase. CH_ACK never set while the FSM state is OFF or WAKE.

Source files
------------

// File: rtl/multi_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// multi_clock_gate_ctrl
//   Multi-channel clock-gating controller. Each channel runs its own
//   OFF/WAKE/ON/IDLE state machine. It wakes on activity, delivers WAKE_CYC
//   gated cycles before acknowledging, and gates off after IDLE_LIMIT idle
//   cycles. Each gated clock is built from a latch that is transparent while
//   CLK is low, followed by an AND gate, so the gated clock cannot glitch.
//
// Ports
//   CLK          source clock for all channels
//   RST          asynchronous active-high reset
//   GLOBAL_EN    master enable; low forces every channel to OFF at the next edge
//   CH_REQ       per-channel clock request (level)
//   CH_BUSY      per-channel busy flag; keeps the clock on
//   CH_FORCE_ON  per-channel debug override; keeps the clock on
//   IDLE_LIMIT   idle cycles tolerated before gating off (shared)
//   GATED_CLK    gated clock per channel
//   CH_ACK       channel clock is stable and running
//   GATE_EN      registered-state enable presented to each latch
//   CH_STATE     per-channel state, channel i at bits [2i+1:2i]
//
// Handshake: CH_REQ is a level. CH_ACK rises once the channel has spent one
// full cycle in ON. It stays high while the channel remains in ON. It falls on
// the same edge that takes the channel out of ON.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module multi_clock_gate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                GLOBAL_EN,
  input  logic [NUM_CH-1:0]   CH_REQ,
  input  logic [NUM_CH-1:0]   CH_BUSY,
  input  logic [NUM_CH-1:0]   CH_FORCE_ON,
  input  logic [CNT_W-1:0]    IDLE_LIMIT,
  output logic [NUM_CH-1:0]   GATED_CLK,
  output logic [NUM_CH-1:0]   CH_ACK,
  output logic [NUM_CH-1:0]   GATE_EN,
  output logic [2*NUM_CH-1:0] CH_STATE
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } state_e;

  localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX  = '1;
  localparam logic [CNT_W:0]   ONE_X     = 1;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [3:0]       wake_q  [NUM_CH];
  logic [3:0]       wake_d  [NUM_CH];
  logic [CNT_W-1:0] idle_q  [NUM_CH];
  logic [CNT_W-1:0] idle_d  [NUM_CH];
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] latch_q;
  logic [NUM_CH-1:0] act;

  assign act = CH_REQ | CH_BUSY | CH_FORCE_ON;

  // Next-state logic, one independent FSM per channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      wake_d[i]  = wake_q[i];
      idle_d[i]  = idle_q[i];
      if (!GLOBAL_EN) begin
        state_d[i] = ST_OFF;
      end else begin
        case (state_q[i])
          ST_OFF: begin
            if (act[i]) begin
              state_d[i] = ST_WAKE;
              wake_d[i]  = '0;
            end
          end
          ST_WAKE: begin
            // The request is ignored here on purpose: a wake-up always completes.
            if (wake_q[i] == WAKE_LAST) state_d[i] = ST_ON;
            else                        wake_d[i]  = wake_q[i] + 4'd1;
          end
          ST_ON: begin
            if (!act[i]) begin
              if (IDLE_LIMIT == '0) begin
                state_d[i] = ST_OFF;
              end else begin
                state_d[i] = ST_IDLE;
                idle_d[i]  = '0;
              end
            end
          end
          ST_IDLE: begin
            if (act[i]) begin
              state_d[i] = ST_ON;
            // Compare one bit wider so that a limit lowered below the current
            // count (including 0) still forces OFF at the next edge.
            end else if (({1'b0, idle_q[i]} + ONE_X) >= {1'b0, IDLE_LIMIT}) begin
              state_d[i] = ST_OFF;
            end else if (idle_q[i] != IDLE_MAX) begin
              idle_d[i] = idle_q[i] + 1'b1;
            end
          end
          default: state_d[i] = ST_OFF;
        endcase
      end
      // Acknowledge only after one full ON cycle, and drop it when leaving ON.
      ack_d[i] = (state_q[i] == ST_ON) && (state_d[i] == ST_ON);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_OFF;
        wake_q[i]  <= '0;
        idle_q[i]  <= '0;
      end
      ack_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        wake_q[i]  <= wake_d[i];
        idle_q[i]  <= idle_d[i];
      end
      ack_q <= ack_d;
    end
  end

  // Decode outputs from the registered state only.
  always_comb begin
    GATE_EN  = '0;
    CH_STATE = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      GATE_EN[i]         = (state_q[i] != ST_OFF);
      CH_STATE[2*i +: 2] = state_q[i];
    end
  end

  assign CH_ACK = ack_q;

  // Clock-gate latch: it follows GATE_EN only while CLK is low. Enable changes
  // made during the high phase therefore cannot chop a pulse. Reset clears the
  // latch at once, even in mid-pulse.
  always_latch begin
    if (RST)       latch_q <= '0;
    else if (!CLK) latch_q <= GATE_EN;
  end

  assign GATED_CLK = {NUM_CH{CLK}} & latch_q;

endmodule
